// File: rtl/ifmap_buffer_filler_if.sv
// rtl/ifmap_buffer_filler_if.sv - start/free, memory read, buffer write and status signals of the ifmap filler
interface ifmap_buffer_filler_if #(
    parameter int NUM_BANKS   = 2,
    parameter int BATCH_WORDS = 64,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 8
);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int WADDR_W = $clog2(BATCH_WORDS);

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [CNT_W-1:0]    total_batches;
    logic                free_ifmap_buffer;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                buf_we;
    logic [BANK_W-1:0]   buf_bank;
    logic [WADDR_W-1:0]  buf_waddr;
    logic [DATA_W-1:0]   buf_wdata;
    logic                ifmap_valid;
    logic [BANK_W-1:0]   rd_bank;
    logic                layer_done;
    logic                err_free_underflow;
    logic [31:0]         stall_cycles;

    modport master (
        input  start, base_addr, total_batches, free_ifmap_buffer,
               mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, buf_we, buf_bank, buf_waddr, buf_wdata,
               ifmap_valid, rd_bank, layer_done, err_free_underflow, stall_cycles
    );

    modport slave (
        output start, base_addr, total_batches, free_ifmap_buffer,
               mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, buf_we, buf_bank, buf_waddr, buf_wdata,
               ifmap_valid, rd_bank, layer_done, err_free_underflow, stall_cycles
    );
endinterface

// File: rtl/ifmap_buffer_filler.sv
// rtl/ifmap_buffer_filler.sv - ifmap ping-pong fill FSM; WAIT_SLOT stall counter built only with IFMAP_FILL_PERF_EN
module ifmap_buffer_filler #(
    parameter int NUM_BANKS   = 2,
    parameter int BATCH_WORDS = 64,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ifmap_buffer_filler_if.master bus
);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int WADDR_W = $clog2(BATCH_WORDS);
    localparam int FILL_W  = $clog2(NUM_BANKS + 1);
    localparam logic [FILL_W-1:0]  FULL       = FILL_W'(NUM_BANKS);
    localparam logic [WADDR_W-1:0] WORD_LAST  = '1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WAIT_SLOT, S_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     batch_idx_q, batch_idx_d;
    logic [WADDR_W-1:0]   req_cnt_q, req_cnt_d;
    logic [WADDR_W-1:0]   resp_cnt_q, resp_cnt_d;
    logic [BANK_W-1:0]    fill_bank_q, fill_bank_d;
    logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
    logic [FILL_W-1:0]    filled_q, filled_d;
    logic                 valid_q;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 resp_ok;
    logic                 wr_en;
    logic                 complete;
    logic                 free_ok;
    logic                 more_batches;

    // state and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            batch_idx_q <= '0;
            req_cnt_q   <= '0;
            resp_cnt_q  <= '0;
            fill_bank_q <= '0;
            rd_bank_q   <= '0;
            filled_q    <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            total_q     <= total_d;
            batch_idx_q <= batch_idx_d;
            req_cnt_q   <= req_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            fill_bank_q <= fill_bank_d;
            rd_bank_q   <= rd_bank_d;
            filled_q    <= filled_d;
            valid_q     <= (filled_d != '0);
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // next state: request/response counting, bank pointers, fill level and FSM
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        total_d     = total_q;
        batch_idx_d = batch_idx_q;
        req_cnt_d   = req_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        fill_bank_d = fill_bank_q;
        rd_bank_d   = rd_bank_q;
        err_d       = err_q;
        done_d      = 1'b0;

        // a response is only legal while a granted word of this batch is still unanswered
        resp_ok      = (state_q == S_RESP) || ((state_q == S_REQ) && (resp_cnt_q < req_cnt_q));
        wr_en        = bus.mem_rvalid && resp_ok;
        complete     = wr_en && (resp_cnt_q == WORD_LAST);
        free_ok      = bus.free_ifmap_buffer && ((filled_q != '0) || complete);
        more_batches = (batch_idx_q + CNT_W'(1)) < total_q;

        if (wr_en) resp_cnt_d = resp_cnt_q + WADDR_W'(1);
        if (complete) begin
            fill_bank_d = fill_bank_q + BANK_W'(1);
            batch_idx_d = batch_idx_q + CNT_W'(1);
        end
        if (free_ok) rd_bank_d = rd_bank_q + BANK_W'(1);
        else if (bus.free_ifmap_buffer) err_d = 1'b1;
        filled_d = filled_q + FILL_W'(complete) - FILL_W'(free_ok);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d      = bus.base_addr;
                    total_d     = bus.total_batches;
                    batch_idx_d = '0;
                    req_cnt_d   = '0;
                    resp_cnt_d  = '0;
                    err_d       = 1'b0;
                    if (bus.total_batches == '0) done_d = 1'b1;
                    else state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    req_cnt_d = req_cnt_q + WADDR_W'(1);
                    if (req_cnt_q == WORD_LAST) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (complete) begin
                    if (!more_batches)        state_d = S_DRAIN;
                    else if (filled_d == FULL) state_d = S_WAIT_SLOT;
                    else                       state_d = S_REQ;
                end
            end
            S_WAIT_SLOT: begin
                if (filled_q < FULL) state_d = S_REQ;
            end
            S_DRAIN: begin
                if (filled_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef IFMAP_FILL_PERF_EN
    logic [31:0] stall_q;

    // saturating count of WAIT_SLOT cycles, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          stall_q <= '0;
        else if ((state_q == S_IDLE) && bus.start)           stall_q <= '0;
        else if ((state_q == S_WAIT_SLOT) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.mem_req            = (state_q == S_REQ);
    assign bus.mem_addr           = (state_q == S_REQ) ? (base_q + ADDR_W'({batch_idx_q, req_cnt_q})) : '0;
    assign bus.buf_we             = wr_en;
    assign bus.buf_bank           = fill_bank_q;
    assign bus.buf_waddr          = resp_cnt_q;
    assign bus.buf_wdata          = wr_en ? bus.mem_rdata : '0;
    assign bus.ifmap_valid        = valid_q;
    assign bus.rd_bank            = rd_bank_q;
    assign bus.layer_done         = done_q;
    assign bus.err_free_underflow = err_q;
endmodule

// File: tb/tb_ifmap_buffer_filler.sv
// tb/tb_ifmap_buffer_filler.sv - self-checking bench for ifmap_buffer_filler
module tb_ifmap_buffer_filler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifmap_buffer_filler_if #(.NUM_BANKS(2), .BATCH_WORDS(64), .ADDR_W(16), .DATA_W(64), .CNT_W(8)) bus();

    ifmap_buffer_filler #(.NUM_BANKS(2), .BATCH_WORDS(64), .ADDR_W(16), .DATA_W(64), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic rv_main = 1'b0, rv_mem = 1'b0, free_main = 1'b0, free_mem = 1'b0;
    assign bus.mem_rvalid        = rv_main | rv_mem;
    assign bus.free_ifmap_buffer = free_main | free_mem;

    int gnt_en = 0, gnt_block = 0, stray_req = 0, free_on_rsp = 0;
    int grant_cnt = 0, rsp_cnt = 0, exp_idx = 0, exp_bank = 0;
    logic [15:0] exp_gaddr = '0;
    logic [15:0] mq[$];
    logic [15:0] rsp_a;
    logic        real_rsp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [15:0] a);
        return {48'hC0DE_0000_BEEF, a};
    endfunction

    // memory model: 1-cycle read latency, grant gating, bank/word/data scoreboard
    always begin
        @(negedge clk);
        rv_mem   = 1'b0;
        free_mem = 1'b0;
        real_rsp = 1'b0;
        if (!rst_n) mq.delete();
        else if (mq.size() > 0) begin
            rsp_a = mq.pop_front();
            rv_mem = 1'b1;
            real_rsp = 1'b1;
            bus.mem_rdata = word_of(rsp_a);
        end else if (stray_req > 0) begin
            stray_req--;
            rv_mem = 1'b1;
            bus.mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        bus.mem_gnt = 1'b0;
        if (rst_n && bus.mem_req) begin
            check("mem_addr", 64'(bus.mem_addr), 64'(exp_gaddr));
            if (gnt_block > 0) gnt_block--;
            else if (gnt_en != 0) begin
                bus.mem_gnt = 1'b1;
                mq.push_back(bus.mem_addr);
                exp_gaddr++;
                grant_cnt++;
            end
        end
        if (real_rsp && (free_on_rsp == rsp_cnt + 1)) free_mem = 1'b1;
        #1;
        if (rv_mem) begin
            if (real_rsp) begin
                check("buf_we", 64'(bus.buf_we), 64'(1));
                check("buf_bank", 64'(bus.buf_bank), 64'(exp_bank));
                check("buf_waddr", 64'(bus.buf_waddr), 64'(exp_idx));
                check("buf_wdata", bus.buf_wdata, word_of(rsp_a));
                rsp_cnt++;
                exp_idx = (exp_idx + 1) % 64;
                if (exp_idx == 0) exp_bank = exp_bank ^ 1;
            end else begin
                check("stray_we", 64'(bus.buf_we), 64'(0));
            end
        end
    end

    typedef struct {
        logic       start;
        logic [7:0] total;
        logic       free;
        logic       rv;
        logic       exp_we;
        logic       exp_done;
        logic       exp_err;
        logic       exp_req;
    } vec_t;

    function automatic vec_t mk(int s, int t, int f, int r, int we, int dn, int er, int rq);
        vec_t v;
        v.start = (s != 0); v.total = 8'(t); v.free = (f != 0); v.rv = (r != 0);
        v.exp_we = (we != 0); v.exp_done = (dn != 0); v.exp_err = (er != 0); v.exp_req = (rq != 0);
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        rv_main = 1'b0; free_main = 1'b0; bus.start = 1'b0;
        gnt_en = 0; gnt_block = 0; stray_req = 0; free_on_rsp = 0;
        repeat (2) @(posedge clk);
        exp_idx = 0; exp_bank = 0; grant_cnt = 0; rsp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [7:0] total);
        bus.base_addr = base;
        bus.total_batches = total;
        exp_gaddr = base;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_cnt(input string name, input int which, input int target, input int budget);
        int cur;
        for (int i = 0; i < budget; i++) begin
            cur = (which == 0) ? grant_cnt : rsp_cnt;
            if (cur >= target) break;
            @(negedge clk); #2;
        end
        cur = (which == 0) ? grant_cnt : rsp_cnt;
        check(name, 64'(cur), 64'(target));
    endtask

    task automatic wait_done(input string name, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (bus.layer_done) begin seen = 1; break; end
        end
        check(name, 64'(seen), 64'(1));
    endtask

    task automatic free_once();
        @(negedge clk); free_main = 1'b1;
        @(negedge clk); free_main = 1'b0;
    endtask

    vec_t tbl[10];
    int   req_seen, dn_seen, rsp_before;
    int   exp_stall;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.total_batches = '0;
        bus.mem_gnt = 1'b0; bus.mem_rdata = '0;
`ifdef IFMAP_FILL_PERF_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        //            st tot fr rv | we dn er rq
        tbl[0] = mk(0, 0, 0, 0,   0, 0, 0, 0);
        tbl[1] = mk(0, 0, 1, 0,   0, 0, 1, 0);
        tbl[2] = mk(0, 0, 0, 0,   0, 0, 1, 0);
        tbl[3] = mk(0, 0, 0, 1,   0, 0, 1, 0);
        tbl[4] = mk(1, 0, 0, 0,   0, 1, 0, 0);
        tbl[5] = mk(0, 0, 0, 0,   0, 0, 0, 0);
        tbl[6] = mk(1, 1, 0, 0,   0, 0, 0, 1);
        tbl[7] = mk(0, 0, 1, 0,   0, 0, 1, 1);
        tbl[8] = mk(0, 0, 0, 1,   0, 0, 1, 1);
        tbl[9] = mk(1, 1, 0, 0,   0, 0, 1, 1);

        do_reset();
        #2;
        check("rst_mem_req", 64'(bus.mem_req), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_buf_we", 64'(bus.buf_we), 64'(0));
        check("rst_buf_bank", 64'(bus.buf_bank), 64'(0));
        check("rst_buf_waddr", 64'(bus.buf_waddr), 64'(0));
        check("rst_ifmap_valid", 64'(bus.ifmap_valid), 64'(0));
        check("rst_rd_bank", 64'(bus.rd_bank), 64'(0));
        check("rst_layer_done", 64'(bus.layer_done), 64'(0));
        check("rst_err", 64'(bus.err_free_underflow), 64'(0));
        check("rst_stall", 64'(bus.stall_cycles), 64'(0));

        // underflow, zero-batch layer, ignored start and orphan responses
        exp_gaddr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = tbl[i].start; bus.total_batches = tbl[i].total; bus.base_addr = '0;
            free_main = tbl[i].free; rv_main = tbl[i].rv;
            #1;
            check($sformatf("vec%0d_buf_we", i), 64'(bus.buf_we), 64'(tbl[i].exp_we));
            @(posedge clk); #1;
            check($sformatf("vec%0d_layer_done", i), 64'(bus.layer_done), 64'(tbl[i].exp_done));
            check($sformatf("vec%0d_err", i), 64'(bus.err_free_underflow), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d_mem_req", i), 64'(bus.mem_req), 64'(tbl[i].exp_req));
        end
        @(negedge clk);
        bus.start = 1'b0; free_main = 1'b0; rv_main = 1'b0;

        // three batches, no free: both banks fill, then WAIT_SLOT
        do_reset();
        gnt_en = 1;
        pulse_start(16'h0100, 8'd3);
        wait_cnt("s1_rsp128", 1, 128, 1000);
        @(posedge clk);
        req_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.mem_req) req_seen++;
        end
        check("s1_stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall));
        check("s1_no_req_in_wait", 64'(req_seen), 64'(0));
        check("s1_grants", 64'(grant_cnt), 64'(128));
        check("s1_ifmap_valid", 64'(bus.ifmap_valid), 64'(1));
        check("s1_rd_bank", 64'(bus.rd_bank), 64'(0));

        // one free resumes fetching at 0x180 into bank 0, two more finish the layer
        free_once();
        #2;
        check("s2_rd_bank_after_free", 64'(bus.rd_bank), 64'(1));
        check("s2_ifmap_valid", 64'(bus.ifmap_valid), 64'(1));
        wait_cnt("s2_resume", 0, 129, 20);
        wait_cnt("s2_rsp192", 1, 192, 1000);
        repeat (3) @(negedge clk);
        #2;
        check("s2_valid_full", 64'(bus.ifmap_valid), 64'(1));
        check("s2_layer_done_early", 64'(bus.layer_done), 64'(0));
        @(negedge clk); free_main = 1'b1;
        @(negedge clk); free_main = 1'b1;
        @(negedge clk); free_main = 1'b0;
        dn_seen = 0; req_seen = 0;
        repeat (10) begin
            @(negedge clk); #2;
            if (bus.layer_done) dn_seen++;
            if (bus.mem_req) req_seen++;
        end
        check("s2_done_pulses", 64'(dn_seen), 64'(1));
        check("s2_no_extra_req", 64'(req_seen), 64'(0));
        check("s2_rd_bank_end", 64'(bus.rd_bank), 64'(1));
        check("s2_valid_end", 64'(bus.ifmap_valid), 64'(0));
        check("s2_grants", 64'(grant_cnt), 64'(192));

        // grant withheld for 5 cycles at start and mid-batch
        do_reset();
        gnt_en = 1; gnt_block = 5;
        pulse_start(16'h0200, 8'd1);
        wait_cnt("s3_grant20", 0, 20, 200);
        gnt_block = 5;
        wait_cnt("s3_rsp64", 1, 64, 1000);
        repeat (4) @(negedge clk);
        #2;
        check("s3_grants", 64'(grant_cnt), 64'(64));
        check("s3_gnt_block_used", 64'(gnt_block), 64'(0));
        check("s3_valid", 64'(bus.ifmap_valid), 64'(1));
        free_once();
        wait_done("s3_done", 10);

        // free coincident with the completing response at filled_cnt = 1
        do_reset();
        gnt_en = 1; free_on_rsp = 128;
        pulse_start(16'h0300, 8'd2);
        wait_cnt("s4_rsp128", 1, 128, 1000);
        @(posedge clk); #1;
        check("s4_valid_kept", 64'(bus.ifmap_valid), 64'(1));
        check("s4_rd_bank_adv", 64'(bus.rd_bank), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("s4_valid_still", 64'(bus.ifmap_valid), 64'(1));
        check("s4_no_done_yet", 64'(bus.layer_done), 64'(0));
        free_on_rsp = 0;
        free_once();
        wait_done("s4_done", 10);
        check("s4_rd_bank_end", 64'(bus.rd_bank), 64'(0));
        pulse_start(16'h0400, 8'd1);
        wait_cnt("s4_next_layer_rsp", 1, 192, 1000);
        repeat (2) @(negedge clk);
        #2;
        check("s4_next_rd_bank", 64'(bus.rd_bank), 64'(0));
        free_once();
        wait_done("s4_next_done", 10);

        // reset mid-batch, then orphan responses in IDLE
        do_reset();
        gnt_en = 1;
        pulse_start(16'h0500, 8'd2);
        wait_cnt("s6_grant10", 0, 10, 100);
        rsp_before = rsp_cnt;
        rst_n = 1'b0;
        gnt_en = 0;
        @(posedge clk); #1;
        check("s6_mem_req", 64'(bus.mem_req), 64'(0));
        check("s6_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("s6_buf_we", 64'(bus.buf_we), 64'(0));
        check("s6_ifmap_valid", 64'(bus.ifmap_valid), 64'(0));
        check("s6_layer_done", 64'(bus.layer_done), 64'(0));
        check("s6_err", 64'(bus.err_free_underflow), 64'(0));
        check("s6_rd_bank", 64'(bus.rd_bank), 64'(0));
        check("s6_buf_waddr", 64'(bus.buf_waddr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        stray_req = 3;
        repeat (6) @(negedge clk);
        #2;
        check("s6_stray_consumed", 64'(stray_req), 64'(0));
        check("s6_no_real_rsp", 64'(rsp_cnt), 64'(rsp_before));
        check("s6_idle_no_req", 64'(bus.mem_req), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
